// File: rtl/des_round_ctrl.sv
// DES round sequencer: IP handshake, Feistel round stepping with key-schedule
// rotate control, FP handshake, result hold, and timeout abort.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   block accept handshake; mode latched on accept
//   ip_start/ip_done    initial-permutation launch pulse / completion pulse
//   round_en/round_idx  one round per cycle, index 1..ROUNDS (0 idle)
//   key_shift/key_dir   key-schedule rotate amount / direction
//   fp_start/fp_ready   final-permutation level start / completion
//   out_valid/out_ready result hold handshake
//   busy, err           not idle / one-cycle timeout pulse
module des_round_ctrl #(
  parameter int ROUNDS  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode,
  output logic       ip_start,
  input  logic       ip_done,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       fp_start,
  input  logic       fp_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  localparam int RW = $clog2(ROUNDS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IP   = 3'd1;
  localparam logic [2:0] S_RND  = 3'd2;
  localparam logic [2:0] S_FP   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [RW-1:0] rnd;
  logic [RW-1:0] rnd_nx;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nx;
  logic          dec;
  logic          dec_nx;
  logic          err_q;
  logic          err_nx;

  logic st_idle;
  logic st_ip;
  logic st_rnd;
  logic st_fp;
  logic st_done;
  logic tmo;
  logic last_rnd;

  assign st_idle  = (state == S_IDLE);
  assign st_ip    = (state == S_IP);
  assign st_rnd   = (state == S_RND);
  assign st_fp    = (state == S_FP);
  assign st_done  = (state == S_DONE);

  // Expiry is checked in the last allowed wait cycle so that a
  // completion arriving in that same cycle still takes priority.
  assign tmo      = (tcnt == TW'(TIMEOUT - 1));
  assign last_rnd = (int'(rnd) == ROUNDS);

  always_comb begin
    state_nx = state;
    rnd_nx   = rnd;
    tcnt_nx  = tcnt;
    dec_nx   = dec;
    err_nx   = 1'b0;
    unique case (1'b1)
      st_idle: begin
        if (in_valid) begin
          state_nx = S_IP;
          tcnt_nx  = '0;
          dec_nx   = mode;
        end
      end
      st_ip: begin
        if (ip_done) begin
          state_nx = S_RND;
          rnd_nx   = RW'(1);
        end else if (tmo) begin
          state_nx = S_IDLE;
          tcnt_nx  = '0;
          err_nx   = 1'b1;
        end else begin
          tcnt_nx  = tcnt + TW'(1);
        end
      end
      st_rnd: begin
        if (last_rnd) begin
          state_nx = S_FP;
          rnd_nx   = '0;
          tcnt_nx  = '0;
        end else begin
          rnd_nx   = rnd + RW'(1);
        end
      end
      st_fp: begin
        if (fp_ready) begin
          state_nx = S_DONE;
          tcnt_nx  = '0;
        end else if (tmo) begin
          state_nx = S_IDLE;
          tcnt_nx  = '0;
          err_nx   = 1'b1;
        end else begin
          tcnt_nx  = tcnt + TW'(1);
        end
      end
      st_done: begin
        if (out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        rnd_nx   = '0;
        tcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rnd   <= '0;
      tcnt  <= '0;
      dec   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      rnd   <= rnd_nx;
      tcnt  <= tcnt_nx;
      dec   <= dec_nx;
      err_q <= err_nx;
    end
  end

  // DES key schedule: single rotate on rounds 1,2,9,16, double elsewhere.
  // Decrypt rotates right and skips the rotate on round 1.
  logic r1;
  logic r2;
  logic r9;
  logic r16;
  logic one_sh;
  logic no_sh;

  assign r1     = (int'(rnd) == 1);
  assign r2     = (int'(rnd) == 2);
  assign r9     = (int'(rnd) == 9);
  assign r16    = (int'(rnd) == 16);
  assign no_sh  = dec && r1;
  assign one_sh = (!dec && r1) || r2 || r9 || r16;

  always_comb begin
    key_shift = 2'd0;
    key_dir   = 1'b0;
    if (st_rnd) begin
      key_dir = dec;
      unique case (1'b1)
        no_sh:   key_shift = 2'd0;
        one_sh:  key_shift = 2'd1;
        default: key_shift = 2'd2;
      endcase
    end
  end

  // The index port is 4 bits wide, so round 16 reads back as 0;
  // round_en distinguishes it from idle.
  assign round_idx = 4'(rnd);
  assign in_ready  = st_idle;
  assign ip_start  = st_ip && (tcnt == '0);
  assign round_en  = st_rnd;
  assign fp_start  = st_fp;
  assign out_valid = st_done;
  assign busy      = !st_idle;
  assign err       = err_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Randomized scoreboard bench for des_round_ctrl.
// Driver pushes expected round/done/err events; monitor pops and compares.
module tb_des_round_ctrl;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic       ip_done = 1'b0;
  logic       fp_ready = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       ip_start;
  logic       round_en;
  logic [3:0] round_idx;
  logic [1:0] key_shift;
  logic       key_dir;
  logic       fp_start;
  logic       out_valid;
  logic       busy;
  logic       err;

  des_round_ctrl #(.ROUNDS(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .ip_start(ip_start), .ip_done(ip_done),
    .round_en(round_en), .round_idx(round_idx),
    .key_shift(key_shift), .key_dir(key_dir),
    .fp_start(fp_start), .fp_ready(fp_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 = round, 1 = done handshake, 2 = err pulse
  typedef struct {
    int kind;
    int idx;
    int shift;
    int dir;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   enc_tab[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push_ev(int k, int i, int s, int d);
    exp_t e;
    e.kind  = k;
    e.idx   = i;
    e.shift = s;
    e.dir   = d;
    sbq.push_back(e);
  endfunction

  function automatic void push_round(int m, int r);
    int s;
    s = (m == 1 && r == 1) ? 0 : enc_tab[r-1];
    push_ev(0, r % 16, s, m);
  endfunction

  function automatic void push_block(int m, bit ok_ip, bit ok_fp);
    if (!ok_ip) begin
      push_ev(2, 0, 0, 0);
      return;
    end
    for (int r = 1; r <= 16; r++) push_round(m, r);
    push_ev(ok_fp ? 1 : 2, 0, 0, 0);
  endfunction

  task automatic mon_pop(input int kind);
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_unexpected: got event %0d want none at %0t",
               kind, $time);
      return;
    end
    e = sbq.pop_front();
    check("sb_kind", kind, e.kind);
    if (kind == 0 && e.kind == 0) begin
      check("round_idx", round_idx, e.idx);
      check("key_shift", key_shift, e.shift);
      check("key_dir", key_dir, e.dir);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (round_en) mon_pop(0);
        else check("key_idle", {key_shift, key_dir}, 0);
        if (out_valid && out_ready) mon_pop(1);
        if (err) mon_pop(2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int m, input int ipd,
                           input int fpd, input int ord);
    bit ok_ip;
    bit ok_fp;
    int w;
    ok_ip = (ipd <= TMO);
    ok_fp = (fpd <= TMO);
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_wait", in_ready, 1);
    push_block(m, ok_ip, ok_fp);
    in_valid = 1'b1;
    mode = m[0];
    tick();
    in_valid = 1'b0;
    mode = 1'($urandom);
    check("ip_start", ip_start, 1);
    for (int c = 1; c <= TMO; c++) begin
      if (c == 2) check("ip_start_once", ip_start, 0);
      if (c == ipd) ip_done = 1'b1;
      tick();
      ip_done = 1'b0;
      if (c == ipd) break;
    end
    if (!ok_ip) begin
      ip_done = 1'b1;
      tick();
      ip_done = 1'b0;
      check("idle_after_ip_tmo", in_ready, 1);
      check("no_round_after_tmo", round_en, 0);
      return;
    end
    for (int r = 1; r <= 16; r++) begin
      fp_ready = ($urandom_range(0, 3) == 0);
      ip_done  = ($urandom_range(0, 3) == 0);
      tick();
    end
    fp_ready = 1'b0;
    ip_done  = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      check("fp_start", fp_start, 1);
      ip_done = ($urandom_range(0, 2) == 0);
      if (c == fpd) fp_ready = 1'b1;
      tick();
      fp_ready = 1'b0;
      ip_done  = 1'b0;
      if (c == fpd) break;
    end
    if (!ok_fp) begin
      check("idle_after_fp_tmo", in_ready, 1);
      return;
    end
    for (int k = 0; k < ord; k++) begin
      check("out_valid_hold", out_valid, 1);
      check("in_ready_done", in_ready, 0);
      in_valid = 1'($urandom);
      tick();
      in_valid = 1'b0;
    end
    check("out_valid_final", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_done", in_ready, 1);
    check("out_valid_clear", out_valid, 0);
  endtask

  task automatic check_reset_outs();
    check("rst_in_ready", in_ready, 1);
    check("rst_ip_start", ip_start, 0);
    check("rst_round_en", round_en, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_key", {key_shift, key_dir}, 0);
    check("rst_fp_start", fp_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_block(0, 2, 2, 0);
    run_block(1, 2, 2, 0);
    run_block(0, TMO + 1, 1, 0);
    run_block(1, 1, 2, 5);
    run_block(0, 1, TMO + 1, 0);
    run_block(1, TMO, TMO, 1);

    // reset while round 7 is executing
    for (int r = 1; r <= 6; r++) push_round(0, r);
    in_valid = 1'b1;
    mode = 1'b0;
    tick();
    in_valid = 1'b0;
    ip_done = 1'b1;
    tick();
    ip_done = 1'b0;
    repeat (6) tick();
    check("pre_rst_idx", round_idx, 7);
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("sb_after_reset", sbq.size(), 0);
    run_block(0, 1, 1, 0);

    for (int b = 0; b < 20; b++) begin
      run_block(int'($urandom_range(0, 1)),
                int'($urandom_range(1, TMO + 1)),
                int'($urandom_range(1, TMO + 1)),
                int'($urandom_range(0, 4)));
    end

    repeat (4) tick();
    check("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
